// File: rtl/button_pkg.sv
// Shared types and default timing constants for the pushbutton decoder.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  localparam int CLK_HZ        = 12000000;
  localparam int DEBOUNCE_10MS = 120000;
  localparam int LONG_1S       = 12000000;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter.
// din is active-high; reset loads the released (0) level everywhere.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // Any cycle agreeing with the current level restarts the count.
      if (sync_p1 != level) begin
        if (db_cnt == CNT_LAST) begin
          level  <= ~level;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/button_press_decoder.sv
// Debounced pushbutton classifier: emits one-cycle short/long press pulses
// and a held_long flag for the duration of a long press.
module button_press_decoder
  import button_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int LONG_CYCLES     = LONG_1S
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_raw,
  output logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic held_long
);

  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_CYCLES);

  logic          pressed;
  state_t        state;
  state_t        state_d;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_d;
  logic          short_d;
  logic          long_d;
  logic          held_d;

  assign pressed = btn_raw ^ ACTIVE_LOW;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk   (clk),
    .resetn(resetn),
    .din   (pressed),
    .level (btn_level)
  );

  always_comb begin
    state_d    = state;
    hold_cnt_d = hold_cnt;
    short_d    = 1'b0;
    long_d     = 1'b0;
    held_d     = held_long;
    case (state)
      IDLE: begin
        if (btn_level) begin
          state_d    = PRESSED;
          hold_cnt_d = HW'(1);
        end else begin
          hold_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
          short_d    = 1'b1;
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else if (hold_cnt == LONG_LAST) begin
          long_d     = 1'b1;
          held_d     = 1'b1;
          state_d    = LONG_HELD;
          hold_cnt_d = LONG_MAX;
        end else if (hold_cnt != LONG_MAX) begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
      end
      LONG_HELD: begin
        // Release after a long press ends silently.
        if (!btn_level) begin
          held_d     = 1'b0;
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
        held_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      held_long   <= 1'b0;
    end else begin
      state       <= state_d;
      hold_cnt    <= hold_cnt_d;
      short_press <= short_d;
      long_press  <= long_d;
      held_long   <= held_d;
    end
  end

endmodule

// File: tb/tb_button_press_decoder.sv
// Scoreboard bench for button_press_decoder with short debounce/long timings.
module tb_button_press_decoder;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int LAT  = 2 + DB;

  localparam int K_RISE  = 0;
  localparam int K_FALL  = 1;
  localparam int K_SHORT = 2;
  localparam int K_LONG  = 3;
  localparam int K_HLR   = 4;
  localparam int K_HLF   = 5;

  typedef struct {
    int k;
    int c;
  } ev_t;

  logic clk;
  logic resetn;
  logic btn_raw;
  logic btn_level;
  logic short_press;
  logic long_press;
  logic held_long;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic lvl_q = 1'b0;
  logic hl_q = 1'b0;
  ev_t  sb[$];

  button_press_decoder #(
    .ACTIVE_LOW     (1'b1),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .short_press(short_press),
    .long_press (long_press),
    .held_long  (held_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int k, input int c);
    ev_t e;
    int  i;
    e.k = k;
    e.c = c;
    i = 0;
    while (i < sb.size() && (sb[i].c < c || (sb[i].c == c && sb[i].k <= k))) i++;
    sb.insert(i, e);
  endfunction

  // Expected events for one debounced-high interval [rise, fall).
  function automatic void push_press(input int rise, input int fall);
    push_ev(K_RISE, rise);
    push_ev(K_FALL, fall);
    if (fall - rise >= LONG) begin
      push_ev(K_LONG, rise + LONG);
      push_ev(K_HLR, rise + LONG);
      push_ev(K_HLF, fall + 1);
    end else begin
      push_ev(K_SHORT, fall + 1);
    end
  endfunction

  task automatic observe(input int k);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_event_kind", k, 99);
    end else begin
      e = sb.pop_front();
      chk("event_kind", k, e.k);
      chk("event_cycle", cyc, e.c);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (btn_level === 1'b1 && lvl_q === 1'b0) observe(K_RISE);
      if (btn_level === 1'b0 && lvl_q === 1'b1) observe(K_FALL);
      if (short_press !== 1'b0) observe(K_SHORT);
      if (long_press !== 1'b0) observe(K_LONG);
      if (held_long === 1'b1 && hl_q === 1'b0) observe(K_HLR);
      if (held_long === 1'b0 && hl_q === 1'b1) observe(K_HLF);
      if (short_press === 1'b1 && long_press === 1'b1) chk("short_long_exclusive", 1, 0);
      lvl_q = btn_level;
      hl_q  = held_long;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_btn_level"}, btn_level, 0);
    chk({tag, "_short_press"}, short_press, 0);
    chk({tag, "_long_press"}, long_press, 0);
    chk({tag, "_held_long"}, held_long, 0);
  endtask

  task automatic clean_press(input int hold);
    int es;
    es = cyc;
    btn_raw = 1'b0;
    push_press(es + LAT, es + LAT + hold);
    tick(hold);
    btn_raw = 1'b1;
    tick(40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int es;
    int r;
    int glitch_val[6];
    int glitch_len[6];
    glitch_val = '{0, 1, 0, 1, 0, 1};
    glitch_len = '{1, 2, 3, 1, 2, 1};

    resetn  = 1'b0;
    btn_raw = 1'b1;
    tick(3);
    check_outputs_zero("reset");
    resetn = 1'b1;
    lvl_q  = 1'b0;
    hl_q   = 1'b0;
    mon_en = 1'b1;
    tick(100);
    check_outputs_zero("idle");

    clean_press(10);
    clean_press(40);
    clean_press(LONG - 1);
    clean_press(LONG);

    // Low glitches shorter than the debounce window, then a steady press.
    for (int i = 0; i < 6; i++) begin
      btn_raw = glitch_val[i][0];
      tick(glitch_len[i]);
    end
    clean_press(12);

    // Reset while PRESSED with hold_cnt at 10; the button stays down.
    es = cyc;
    btn_raw = 1'b0;
    push_ev(K_RISE, es + LAT);
    wait_until(es + LAT + 10);
    resetn = 1'b0;
    push_ev(K_FALL, es + LAT + 11);
    tick(1);
    check_outputs_zero("mid_reset");
    resetn = 1'b1;
    r = cyc;
    push_press(r + LAT, r + LAT + 9);
    wait_until(r + 9);
    btn_raw = 1'b1;
    tick(60);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
